// File: rtl/bilinear_scan_ctrl_if.sv
// Interface bundling the scan controller's frame-control, pacing and
// datapath-facing signals. The controller takes the slave modport; the
// frame/line-buffer manager side (or a bench) takes the master modport.
interface bilinear_scan_ctrl_if #(
    parameter int INDEX_WIDTH = 11,
    parameter int INT_WIDTH   = 8,
    parameter int FIX_WIDTH   = 12
);
    // Frame control and configuration
    logic                           start_i;
    logic [15:0]                    dest_width_i;
    logic [15:0]                    dest_height_i;
    logic [15:0]                    src_height_i;
    logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factory_i;

    // Pacing inputs
    logic [INDEX_WIDTH:0]           src_rows_avail_i;
    logic                           out_afull_i;
    logic                           pix_valid_i;

    // Coordinate issue and status
    logic [INDEX_WIDTH-1:0]         destx_o;
    logic [INDEX_WIDTH-1:0]         desty_o;
    logic                           coord_valid_o;
    logic                           line_done_o;
    logic                           busy_o;
    logic                           done_o;

    modport master (
        output start_i, dest_width_i, dest_height_i, src_height_i,
               scale_factory_i, src_rows_avail_i, out_afull_i, pix_valid_i,
        input  destx_o, desty_o, coord_valid_o, line_done_o, busy_o, done_o
    );

    modport slave (
        input  start_i, dest_width_i, dest_height_i, src_height_i,
               scale_factory_i, src_rows_avail_i, out_afull_i, pix_valid_i,
        output destx_o, desty_o, coord_valid_o, line_done_o, busy_o, done_o
    );
endinterface

// File: rtl/bilinear_scan_ctrl.sv
// Scan controller for the grayscale bilinear scaler. Walks the destination
// raster line by line, holds each line until the source rows it needs are
// resident in the line buffer, issues one coordinate per cycle unless the
// downstream is almost full, and counts finished pixels to end the frame.
module bilinear_scan_ctrl #(
    parameter int INDEX_WIDTH = 11,
    parameter int INT_WIDTH   = 8,
    parameter int FIX_WIDTH   = 12
) (
    input logic               clk_i,
    input logic               rst_i,
    bilinear_scan_ctrl_if.slave bus
);

    localparam int SCL_W  = INT_WIDTH + FIX_WIDTH;
    localparam int PROD_W = INDEX_WIDTH + INT_WIDTH + FIX_WIDTH;
    localparam int CNT_W  = 2 * INDEX_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LINE_SETUP,
        S_WAIT_ROWS,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                 state_r, state_nx;

    // Frame configuration, captured on the accepted start
    logic [15:0]            width_r;
    logic [15:0]            height_r;
    logic [15:0]            src_height_r;
    logic [SCL_W-1:0]       scale_r;
    logic [31:0]            total_r;

    // Raster position, row requirement and output-beat counter
    logic [INDEX_WIDTH-1:0] destx_r;
    logic [INDEX_WIDTH-1:0] desty_r;
    logic [31:0]            need_r;
    logic [CNT_W-1:0]       count_r;
    logic                   line_done_r;

    // Decode of the current cycle
    logic                   accept;
    logic                   issue;
    logic                   last_x;
    logic                   last_y;
    logic                   rows_ok;
    logic                   terminal;
    logic [PROD_W-1:0]      prod;
    logic [31:0]            need_calc;

    // Source rows required by the current line: the integer source row of
    // desty plus the row below it, never more than the source has.
    always_comb begin
        prod      = PROD_W'(desty_r) * PROD_W'(scale_r);
        need_calc = 32'(prod >> FIX_WIDTH) + 32'd2;
        if (need_calc > 32'(src_height_r)) begin
            need_calc = 32'(src_height_r);
        end
    end

    // Next-state and issue decode; the frame-end counter terminal overrides
    // whatever the raster walk wants to do.
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state_r;
        issue    = 1'b0;
        accept   = (state_r == S_IDLE) && bus.start_i;
        last_x   = (16'(destx_r) == (width_r - 16'd1));
        last_y   = (16'(desty_r) == (height_r - 16'd1));
        rows_ok  = (32'(bus.src_rows_avail_i) >= need_r);
        terminal = bus.pix_valid_i
                   && ((state_r == S_RUN) || (state_r == S_DRAIN))
                   && ((32'(count_r) + 32'd1) == total_r);

        case (state_r)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_nx = S_LINE_SETUP;
                end
            end
            S_LINE_SETUP: begin
                state_nx = S_WAIT_ROWS;
            end
            S_WAIT_ROWS: begin
                if (rows_ok) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.out_afull_i) begin
                    issue = 1'b1;
                    if (last_x) begin
                        state_nx = last_y ? S_DRAIN : S_LINE_SETUP;
                    end
                end
            end
            S_DRAIN: begin
                state_nx = S_DRAIN;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (terminal) begin
            state_nx = S_IDLE;
        end
    end

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Capture the frame configuration when a start is accepted.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            width_r      <= '0;
            height_r     <= '0;
            src_height_r <= '0;
            scale_r      <= '0;
            total_r      <= '0;
        end else if (accept) begin
            width_r      <= bus.dest_width_i;
            height_r     <= bus.dest_height_i;
            src_height_r <= bus.src_height_i;
            scale_r      <= bus.scale_factory_i;
            total_r      <= 32'(bus.dest_width_i) * 32'(bus.dest_height_i);
        end
    end

    // Raster walk: x restarts when a line is released, advances per issue;
    // y restarts on start and advances after the last pixel of a line.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            destx_r     <= '0;
            desty_r     <= '0;
            need_r      <= '0;
            line_done_r <= 1'b0;
        end else begin
            line_done_r <= issue && last_x;

            if (state_r == S_LINE_SETUP) begin
                need_r <= need_calc;
            end

            if ((state_r == S_WAIT_ROWS) && rows_ok) begin
                destx_r <= '0;
            end else if (issue && !last_x) begin
                destx_r <= destx_r + INDEX_WIDTH'(1);
            end

            if (accept) begin
                desty_r <= '0;
            end else if (issue && last_x && !last_y) begin
                desty_r <= desty_r + INDEX_WIDTH'(1);
            end
        end
    end

    // Output-beat counter: counts datapath results while a frame is open
    // and clears on the terminal beat; beats seen in IDLE are dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_r <= '0;
        end else if (terminal || (state_r == S_IDLE)) begin
            count_r <= '0;
        end else if (bus.pix_valid_i) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign bus.destx_o       = destx_r;
    assign bus.desty_o       = desty_r;
    assign bus.coord_valid_o = issue;
    assign bus.line_done_o   = line_done_r;
    assign bus.done_o        = terminal;
    assign bus.busy_o        = (state_r != S_IDLE) && !terminal;

endmodule

// File: tb/tb_bilinear_scan_ctrl.sv
// Bench for bilinear_scan_ctrl: a table of frame configurations with
// hand-computed beat counts and issue timing, plus directed sequences for
// row gating, back-pressure, ignored starts, mid-frame reset and 1x1 frames.
// A three-stage stub stands in for the datapath: a coordinate issued in
// cycle c returns pix_valid in cycle c+3.
module tb_bilinear_scan_ctrl;

    localparam int IW = 11;
    localparam int IN = 8;
    localparam int FX = 12;

    logic clk;
    logic rst_n;
    int   cyc;

    bilinear_scan_ctrl_if #(.INDEX_WIDTH(IW), .INT_WIDTH(IN), .FIX_WIDTH(FX)) bus ();

    bilinear_scan_ctrl #(.INDEX_WIDTH(IW), .INT_WIDTH(IN), .FIX_WIDTH(FX)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stub
    logic [2:0] pipe;
    logic       pv_force;
    initial pipe = '0;
    always @(posedge clk) pipe <= {pipe[1:0], bus.coord_valid_o};
    assign bus.pix_valid_i = pipe[2] | pv_force;

    // Source-row availability: fixed, or a ramp of one row per 10 cycles
    logic        ramp_en;
    int          ramp_base;
    int          rows_fixed;
    logic [IW:0] rows_val;
    always_comb begin
        int k;
        k = (cyc - ramp_base) / 10;
        if (k > 16) k = 16;
        if (k < 0) k = 0;
        rows_val = ramp_en ? (IW+1)'(k) : (IW+1)'(rows_fixed);
    end
    assign bus.src_rows_avail_i = rows_val;

    // Scoreboard state kept by the monitor
    int total, bad;
    int cur_w, exp_x, exp_y;
    int issue_cnt, line_cnt, done_cnt;
    int raster_err, ld_err, afull_err, busy_err;
    int last_issue, done_cyc, start_cyc;
    int first_issue [64];
    logic in_frame, prev_last;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (bus.coord_valid_o) begin
            if (bus.out_afull_i) afull_err++;
            if (int'(bus.destx_o) != exp_x || int'(bus.desty_o) != exp_y) raster_err++;
            if (bus.destx_o == '0 && int'(bus.desty_o) < 64) first_issue[int'(bus.desty_o)] = cyc;
            last_issue = cyc;
            issue_cnt++;
            if (exp_x == cur_w - 1) begin
                exp_x = 0;
                exp_y++;
            end else begin
                exp_x++;
            end
        end
        if (bus.line_done_o) begin
            line_cnt++;
            if (!prev_last) ld_err++;
        end
        prev_last = bus.coord_valid_o && (int'(bus.destx_o) == cur_w - 1);
        if (bus.done_o) begin
            done_cnt++;
            done_cyc = cyc;
            if (bus.busy_o) busy_err++;
            in_frame = 1'b0;
        end else if (in_frame && cyc > start_cyc && !bus.busy_o) begin
            busy_err++;
        end
    end

    task automatic begin_frame(input int w, input int h, input int sh, input int sc);
        @(posedge clk); #1;
        bus.dest_width_i    = 16'(w);
        bus.dest_height_i   = 16'(h);
        bus.src_height_i    = 16'(sh);
        bus.scale_factory_i = (IN+FX)'(sc);
        cur_w = w; exp_x = 0; exp_y = 0;
        issue_cnt = 0; line_cnt = 0; done_cnt = 0;
        raster_err = 0; ld_err = 0; afull_err = 0; busy_err = 0;
        last_issue = 0; done_cyc = 0;
        start_cyc = cyc; ramp_base = cyc;
        in_frame = 1'b1;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_issues(input string name, input int n, input int budget);
        int i;
        i = 0;
        while (issue_cnt < n && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        if (issue_cnt < n) check({name, "_issue_timeout"}, issue_cnt, n);
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        while (done_cnt == 0 && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        repeat (6) @(posedge clk);
        #1;
        check({name, "_done_count"}, done_cnt, 1);
    endtask

    task automatic check_frame(input string name, input int beats, input int lines, input int last_rel);
        check({name, "_beats"}, issue_cnt, beats);
        check({name, "_line_done"}, line_cnt, lines);
        check({name, "_raster_err"}, raster_err, 0);
        check({name, "_line_done_err"}, ld_err, 0);
        check({name, "_afull_err"}, afull_err, 0);
        check({name, "_busy_err"}, busy_err, 0);
        check({name, "_last_issue_cyc"}, last_issue - start_cyc, last_rel);
        check({name, "_done_latency"}, done_cyc - last_issue, 3);
        check({name, "_busy_after"}, int'(bus.busy_o), 0);
    endtask

    typedef struct {
        string name;
        int    w, h, src_h, scale, rows;
        int    exp_beats, exp_lines, exp_last_rel;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int   l_prev, need, r, f;
        int   snap;
        total = 0; bad = 0;
        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.dest_width_i = '0; bus.dest_height_i = '0;
        bus.src_height_i = '0; bus.scale_factory_i = '0; bus.out_afull_i = 1'b0;
        pv_force = 1'b0; ramp_en = 1'b0; ramp_base = 0; rows_fixed = 0;
        cur_w = 1; exp_x = 0; exp_y = 0; in_frame = 1'b0; prev_last = 1'b0;
        issue_cnt = 0; line_cnt = 0; done_cnt = 0; start_cyc = 0;
        raster_err = 0; ld_err = 0; afull_err = 0; busy_err = 0;

        // Frame table: last issue = start + h*(w+2) with rows always ready
        vecs[0] = '{"f4x2",  4, 2, 16, 'h0800, 16,  8, 2, 12};
        vecs[1] = '{"f1x1",  1, 1,  1, 'h1000,  1,  1, 1,  3};
        vecs[2] = '{"f3x4",  3, 4,  8, 'h2000,  8, 12, 4, 20};
        vecs[3] = '{"f1x3",  1, 3,  3, 'h1000,  3,  3, 3,  9};
        vecs[4] = '{"f5x1",  5, 1,  2, 'h2000,  2,  5, 1,  7};
        vecs[5] = '{"f2x3c", 2, 3,  3, 'h2000,  3,  6, 3, 12};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_coord_valid", int'(bus.coord_valid_o), 0);
        check("reset_busy", int'(bus.busy_o), 0);
        check("reset_done", int'(bus.done_o), 0);
        check("reset_line_done", int'(bus.line_done_o), 0);
        check("reset_destx", int'(bus.destx_o), 0);
        check("reset_desty", int'(bus.desty_o), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            rows_fixed = vecs[i].rows;
            begin_frame(vecs[i].w, vecs[i].h, vecs[i].src_h, vecs[i].scale);
            wait_done(vecs[i].name, 500);
            check_frame(vecs[i].name, vecs[i].exp_beats, vecs[i].exp_lines, vecs[i].exp_last_rel);
        end

        // 1x1 frame, then stray pix_valid pulses after done
        rows_fixed = 1;
        begin_frame(1, 1, 1, 'h1000);
        wait_done("one", 200);
        check_frame("one", 1, 1, 3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; pv_force = 1'b1;
            @(posedge clk); #1; pv_force = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1;
        check("one_extra_pv_done", done_cnt, 1);
        check("one_extra_pv_busy", int'(bus.busy_o), 0);
        check("one_extra_pv_issues", issue_cnt, 1);

        // Row gating with a ramping row count; line 7 needs the clamp
        ramp_en = 1'b1;
        begin_frame(8, 8, 16, 'h2000);
        wait_done("ramp", 600);
        l_prev = 0;
        for (int y = 0; y < 8; y++) begin
            need = 2 * y + 2;
            if (need > 16) need = 16;
            r = 10 * need;
            f = ((l_prev + 2) > r ? (l_prev + 2) : r) + 1;
            check($sformatf("ramp_first_issue_y%0d", y), first_issue[y] - start_cyc, f);
            l_prev = f + 7;
        end
        check_frame("ramp", 64, 8, l_prev);
        ramp_en = 1'b0;

        // Back-pressure: 5 stalled cycles mid-line on a 16-wide line
        rows_fixed = 16;
        begin_frame(16, 1, 16, 'h1000);
        wait_issues("afull", 6, 100);
        bus.out_afull_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.out_afull_i = 1'b0;
        wait_done("afull", 200);
        check_frame("afull", 16, 1, 23);

        // start pulses in RUN and in DRAIN are ignored
        begin_frame(8, 2, 16, 'h0800);
        wait_issues("ign", 3, 100);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        wait_issues("ign", 16, 100);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        wait_done("ign", 200);
        check_frame("ign", 16, 2, 20);
        begin_frame(8, 2, 16, 'h0800);
        wait_done("ign2", 200);
        check_frame("ign2", 16, 2, 20);

        // Reset for one cycle in the middle of a 32x32 frame
        rows_fixed = 32;
        begin_frame(32, 32, 32, 'h1000);
        wait_issues("rst", 40, 400);
        in_frame = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_coord_valid", int'(bus.coord_valid_o), 0);
        check("midrst_busy", int'(bus.busy_o), 0);
        check("midrst_line_done", int'(bus.line_done_o), 0);
        check("midrst_destx", int'(bus.destx_o), 0);
        check("midrst_desty", int'(bus.desty_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        snap = issue_cnt;
        repeat (8) @(posedge clk);
        #1;
        check("postrst_busy", int'(bus.busy_o), 0);
        check("postrst_no_issue", issue_cnt - snap, 0);
        check("postrst_no_done", done_cnt, 0);
        begin_frame(32, 32, 32, 'h1000);
        wait_done("rst2", 3000);
        check_frame("rst2", 1024, 32, 32 * 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bilinear_scan_ctrl.md
Name: bilinear_scan_ctrl

Overview:
- Sequences the grayscale bilinear scaler datapath for one frame.
- Generates the destination raster coordinates and paces issue against source-row availability and downstream back-pressure.
- Counts the datapath's output beats and signals frame completion.
- Sits between the frame/line-buffer manager and the scaler datapath; the destination coordinate outputs drive the datapath's destination x/y inputs directly.

Parameters:
INDEX_WIDTH, 11, width of destination/source coordinates and row counts
INT_WIDTH, 8, integer bits of the y scale factor
FIX_WIDTH, 12, fractional bits of the y scale factor

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-low
start_i  input  1  frame start pulse; honoured only in IDLE
dest_width_i  input  16  destination width in pixels; ≥1, ≤2^INDEX_WIDTH
dest_height_i  input  16  destination height in lines; ≥1, ≤2^INDEX_WIDTH
src_height_i  input  16  source height in lines
scale_factory_i  input  INT_WIDTH+FIX_WIDTH  src_height/dest_height, unsigned fixed point
src_rows_avail_i  input  INDEX_WIDTH+1  count of source rows currently resident in the line buffer, from row 0
out_afull_i  input  1  downstream almost-full; stall issue while high
pix_valid_i  input  1  datapath output-valid, one per finished pixel
destx_o  output  INDEX_WIDTH  destination x to datapath
desty_o  output  INDEX_WIDTH  destination y to datapath
coord_valid_o  output  1  destx_o/desty_o valid this cycle (pixel issued)
line_done_o  output  1  one-cycle pulse after last pixel of a line is issued
busy_o  output  1  high from accepted start until done_o
done_o  output  1  one-cycle pulse when all dest_width*dest_height output beats are counted

Behaviour:
- Reset (rst_i low, asynchronous): state=IDLE; all outputs 0; internal counters 0.
- Configuration inputs are sampled into registers on the accepted start_i and held for the frame.
- States: IDLE, LINE_SETUP, WAIT_ROWS, RUN, DRAIN.
- IDLE: on start_i, latch config, desty=0, busy_o=1 next cycle, go LINE_SETUP. start_i in any other state is ignored.
- LINE_SETUP (1 cycle):
  - need = floor(desty*scale_factory >> FIX_WIDTH) + 2.
  - The product is full width (INDEX_WIDTH+INT_WIDTH+FIX_WIDTH), no truncation before the shift.
  - need is clamped to src_height_i. Go WAIT_ROWS.
- WAIT_ROWS: stay until src_rows_avail_i ≥ need; then destx=0, go RUN. Satisfied on the first cycle → RUN next cycle.
- RUN:
  - Each cycle with out_afull_i low: coord_valid_o=1 with current destx/desty, then destx++.
  - out_afull_i high: coord_valid_o=0, destx held. Issue is never mid-cycle gated; afull takes effect in the same cycle it is sampled.
  - Last pixel (destx=dest_width-1) issued: line_done_o pulses next cycle.
  - If desty=dest_height-1 → DRAIN; else desty++ → LINE_SETUP.
  - No coord_valid_o gap is allowed other than the LINE_SETUP/WAIT_ROWS cycles and afull stalls.
- Output counter:
  - Counts pix_valid_i in every state except IDLE, width 2*INDEX_WIDTH.
  - When count reaches dest_width*dest_height (in RUN or DRAIN): done_o pulses one cycle, busy_o drops the same cycle, state→IDLE, count cleared.
  - pix_valid_i beyond the expected total is ignored.
- Simultaneous events:
  - The final issue and the counter terminal cannot coincide, since datapath latency is ≥1.
  - If they do anyway (test stub), done_o still fires and the state goes IDLE.
- src_rows_avail_i may change at any time; only the WAIT_ROWS comparison uses it.
- dest_width=1: every line is a single issue cycle followed by LINE_SETUP.
- Asynchronous reset mid-frame: immediate return to IDLE; the in-flight datapath beats are not counted afterwards.

Test Plan:
- 4x2 dest, scale_y=0x0800 (0.5 with FIX 12), rows_avail=16, afull=0, stub datapath with 3-cycle delay → coord_valid runs (0..3,0) then (0..3,1); line_done twice; done_o exactly 3 cycles after last issue; busy_o high from cycle after start to done_o.
- Row gating: dest 8x8, scale_y=0x2000 (2.0), src_height=16, rows_avail ramps 0→16 by 1 every 10 cycles → line y issues only after rows_avail ≥ min(2y+2,16); line 7 need clamped to 16.
- Back-pressure: afull toggles high for 5 cycles mid-line on 16-wide line → exactly 16 coord_valid beats with destx contiguous 0..15, none during afull.
- start_i pulsed during RUN and during DRAIN → ignored; second start after done_o → new frame from (0,0).
- Reset low for 1 cycle mid-RUN of a 32x32 frame → all outputs 0 immediately; afterwards IDLE; a new start completes a normal frame with done after 1024 beats.
- Edge: dest 1x1 → single coord_valid (0,0), line_done, done_o after one pix_valid; extra pix_valid pulses after done do not restart or pulse done.
